seg_display_ctrl: RTL and testbench

Parametrised, memory-mapped seven-segment display peripheral for the extended CPU's external bus. It replaces the fixed four-digit display outputs with NUM_DIGITS hex digits, plus enable, blink and per-digit blank control. The CPU reaches it through the same address and strobe signals it uses for external memory. Registered read-back and a one-cycle acknowledge are provided.

---
 rtl/seg_display_ctrl.sv | 134 +++++++++++++
 tb/tb_seg_display_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// Memory-mapped hex seven-segment display peripheral with enable, blink and per-digit blanking.
// Define SEG_SCAN_EN to build the multiplexed one-digit-at-a-time scan mode.
module seg_display_ctrl #(
  parameter int unsigned         NUM_DIGITS = 4,
  parameter int unsigned         DATA_W     = 16,
  parameter int unsigned         ADDR_W     = 18,
  parameter logic [ADDR_W-1:0]   BASE_ADDR  = 18'h3FF00,
  parameter int unsigned         BLINK_DIV  = 24,
  parameter int unsigned         SCAN_DIV   = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       dir_mem_ex,
  input  logic                    write_ext,
  input  logic                    read_ext,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    ack,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  localparam int unsigned NW = (NUM_DIGITS + 3) / 4;

  logic [3:0]            val [NUM_DIGITS];
  logic                  en;
  logic                  blink;
  logic [NUM_DIGITS-1:0] blank;
  logic [BLINK_DIV-1:0]  blink_cnt;

  logic [ADDR_W-1:0]     offset;
  logic                  is_val, is_ctrl, is_blank, mapped;
  logic                  wr, rd;
  logic [DATA_W-1:0]     rdata;
  logic [7*NUM_DIGITS-1:0] seg_next;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  assign offset = dir_mem_ex - BASE_ADDR;

  always_comb begin
    is_val   = offset < ADDR_W'(NW);
    is_ctrl  = offset == ADDR_W'(NW);
    is_blank = offset == ADDR_W'(NW + 1);
    mapped   = (dir_mem_ex >= BASE_ADDR) && (is_val || is_ctrl || is_blank);
    wr       = write_ext && mapped;
    // a simultaneous read is dropped in favour of the write
    rd       = read_ext && !write_ext && mapped;
  end

  always_comb begin
    rdata = '0;
    if (is_val) begin
      for (int unsigned d = 0; d < NUM_DIGITS; d++)
        if (offset == ADDR_W'(d / 4)) rdata[(d % 4) * 4 +: 4] = val[d];
    end else if (is_ctrl) begin
      rdata[1:0] = {blink, en};
    end else if (is_blank) begin
      rdata[NUM_DIGITS-1:0] = blank;
    end
  end

`ifdef SEG_SCAN_EN
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SCAN_DIV-1:0] scan_cnt;
  logic [IDX_W-1:0]    scan_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_DIV'(1);
      if (&scan_cnt) begin
        if (scan_idx == IDX_W'(NUM_DIGITS - 1)) scan_idx <= '0;
        else                                   scan_idx <= scan_idx + IDX_W'(1);
      end
    end
  end
`endif

  always_comb begin
    seg_next = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      logic lit;
      lit = en && !blank[i] && !(blink && blink_cnt[BLINK_DIV-1]);
`ifdef SEG_SCAN_EN
      lit = lit && (scan_idx == IDX_W'(i));
`endif
      seg_next[7*i +: 7] = lit ? glyph(val[i]) : 7'h7F;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned d = 0; d < NUM_DIGITS; d++) val[d] <= '0;
      en        <= 1'b1;
      blink     <= 1'b0;
      blank     <= '0;
      blink_cnt <= '0;
      data_out  <= '0;
      ack       <= 1'b0;
      seg_out   <= {NUM_DIGITS{7'h40}};
    end else begin
      ack       <= wr || rd;
      data_out  <= rd ? rdata : '0;
      blink_cnt <= blink_cnt + BLINK_DIV'(1);
      if (wr && is_val) begin
        for (int unsigned d = 0; d < NUM_DIGITS; d++)
          if (offset == ADDR_W'(d / 4)) val[d] <= data_in[(d % 4) * 4 +: 4];
      end
      if (wr && is_ctrl) begin
        en    <= data_in[0];
        blink <= data_in[1];
        // restart the period on blink enable so the display opens lit
        if (data_in[1] && !blink) blink_cnt <= '0;
      end
      if (wr && is_blank) blank <= data_in[NUM_DIGITS-1:0];
      seg_out <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed, table-driven bench for seg_display_ctrl (4 digits, short blink and scan periods).
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] dir_mem_ex;
  logic        write_ext;
  logic        read_ext;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        ack;
  logic [27:0] seg_out;

  int tests = 0;
  int fails = 0;

  localparam logic [17:0] A_VAL   = 18'h3FF00;
  localparam logic [17:0] A_CTRL  = 18'h3FF01;
  localparam logic [17:0] A_BLANK = 18'h3FF02;
  localparam logic [27:0] ALL_BLK = 28'hFFFFFFF;
  localparam logic [27:0] RST_SEG = 28'h8102040;

  seg_display_ctrl #(.NUM_DIGITS(4), .DATA_W(16), .ADDR_W(18), .BASE_ADDR(18'h3FF00),
                     .BLINK_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk), .reset(reset), .dir_mem_ex(dir_mem_ex), .write_ext(write_ext),
    .read_ext(read_ext), .data_in(data_in), .data_out(data_out), .ack(ack), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic        re;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic        exp_ack;
    logic [15:0] exp_dout;
    logic [27:0] exp_seg;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic we, re, input logic [17:0] a, input logic [15:0] d,
                              input logic ea, input logic [15:0] ed, input logic [27:0] es);
    vec_t v;
    v.we = we; v.re = re; v.addr = a; v.wdata = d;
    v.exp_ack = ea; v.exp_dout = ed; v.exp_seg = es;
    return v;
  endfunction

  function automatic logic [27:0] pk(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic apply(input logic we, re, input logic [17:0] a, input logic [15:0] d);
    @(negedge clk);
    write_ext = we; read_ext = re; dir_mem_ex = a; data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    write_ext = 1'b0; read_ext = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [27:0] s_a1f8, s_1234, s_beef, exp_s;

  initial begin
    s_a1f8 = pk(7'h08, 7'h79, 7'h0E, 7'h00);
    s_1234 = pk(7'h79, 7'h24, 7'h30, 7'h19);
    s_beef = pk(7'h03, 7'h06, 7'h06, 7'h0E);

    vecs[0]  = mk(1, 0, A_VAL,   16'hA1F8, 1, 16'h0000, s_a1f8);
    vecs[1]  = mk(0, 1, A_VAL,   16'h0000, 1, 16'hA1F8, s_a1f8);
    vecs[2]  = mk(1, 0, A_BLANK, 16'h0005, 1, 16'h0000, pk(7'h08, 7'h7F, 7'h0E, 7'h7F));
    vecs[3]  = mk(0, 1, A_BLANK, 16'h0000, 1, 16'h0005, pk(7'h08, 7'h7F, 7'h0E, 7'h7F));
    vecs[4]  = mk(0, 1, A_CTRL,  16'h0000, 1, 16'h0001, pk(7'h08, 7'h7F, 7'h0E, 7'h7F));
    vecs[5]  = mk(1, 0, A_BLANK, 16'hFFF0, 1, 16'h0000, s_a1f8);
    vecs[6]  = mk(0, 1, A_BLANK, 16'h0000, 1, 16'h0000, s_a1f8);
    vecs[7]  = mk(1, 0, A_CTRL,  16'h0000, 1, 16'h0000, ALL_BLK);
    vecs[8]  = mk(0, 1, A_CTRL,  16'h0000, 1, 16'h0000, ALL_BLK);
    vecs[9]  = mk(1, 0, A_CTRL,  16'hFFFD, 1, 16'h0000, s_a1f8);
    vecs[10] = mk(0, 1, A_CTRL,  16'h0000, 1, 16'h0001, s_a1f8);
    vecs[11] = mk(1, 1, A_VAL,   16'h1234, 1, 16'h0000, s_1234);
    vecs[12] = mk(0, 1, A_VAL,   16'h0000, 1, 16'h1234, s_1234);
    vecs[13] = mk(1, 0, 18'h3FF07, 16'hFFFF, 0, 16'h0000, s_1234);
    vecs[14] = mk(0, 1, 18'h3FF07, 16'h0000, 0, 16'h0000, s_1234);
    vecs[15] = mk(0, 1, 18'h3FEFF, 16'h0000, 0, 16'h0000, s_1234);
    vecs[16] = mk(1, 0, 18'h3FEFF, 16'h0000, 0, 16'h0000, s_1234);
    vecs[17] = mk(1, 0, 18'h3FF03, 16'h0000, 0, 16'h0000, s_1234);
    vecs[18] = mk(0, 1, A_VAL,   16'h0000, 1, 16'h1234, s_1234);

    reset = 1'b0; write_ext = 1'b0; read_ext = 1'b0; dir_mem_ex = '0; data_in = '0;
    repeat (2) @(posedge clk);
    #1 check("reset_seg_async", 32'(seg_out), 32'(RST_SEG));
    @(negedge clk) reset = 1'b1;

`ifdef SEG_SCAN_EN
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      exp_s = ALL_BLK;
      exp_s[7 * (((k - 1) / 4) % 4) +: 7] = 7'h40;
      check($sformatf("scan_k%0d", k), 32'(seg_out), 32'(exp_s));
    end
`else
    repeat (3) @(posedge clk);
    #1;
    check("reset_seg", 32'(seg_out), 32'(RST_SEG));
`endif
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_dout", 32'(data_out), 32'd0);

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
      check($sformatf("v%0d_dout", i), 32'(data_out), 32'(vecs[i].exp_dout));
      idle();
      check($sformatf("v%0d_ack_once", i), 32'(ack), 32'd0);
      check($sformatf("v%0d_dout_clr", i), 32'(data_out), 32'd0);
`ifndef SEG_SCAN_EN
      check($sformatf("v%0d_seg", i), 32'(seg_out), 32'(vecs[i].exp_seg));
`endif
    end

    // back-to-back write then read
    apply(1, 0, A_VAL, 16'hBEEF);
    check("b2b_wr_ack", 32'(ack), 32'd1);
    apply(0, 1, A_VAL, 16'h0000);
    check("b2b_rd_ack", 32'(ack), 32'd1);
    check("b2b_rd_dout", 32'(data_out), 32'hBEEF);
    idle();
    check("b2b_ack_end", 32'(ack), 32'd0);
    check("b2b_dout_end", 32'(data_out), 32'd0);
`ifndef SEG_SCAN_EN
    check("b2b_seg", 32'(seg_out), 32'(s_beef));

    // blink: 8 lit, 8 blank, 8 lit after enabling
    apply(1, 0, A_CTRL, 16'h0003);
    @(negedge clk) write_ext = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      exp_s = (k <= 8 || k >= 17) ? s_beef : ALL_BLK;
      check($sformatf("blink_k%0d", k), 32'(seg_out), 32'(exp_s));
    end
    apply(1, 0, A_CTRL, 16'h0001);
    idle();
`endif

    // reset asserted during a write
    @(negedge clk);
    write_ext = 1'b1; dir_mem_ex = A_VAL; data_in = 16'h5555;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_seg", 32'(seg_out), 32'(RST_SEG));
    check("midrst_dout", 32'(data_out), 32'd0);
    @(negedge clk);
    write_ext = 1'b0; reset = 1'b1;
`ifdef SEG_SCAN_EN
    @(posedge clk); #1;
    check("midrst_scan_idx0", 32'(seg_out), 32'(pk(7'h7F, 7'h7F, 7'h7F, 7'h40)));
`endif
    apply(0, 1, A_VAL, 16'h0000);
    check("midrst_val", 32'(data_out), 32'd0);
    apply(0, 1, A_CTRL, 16'h0000);
    check("midrst_ctrl", 32'(data_out), 32'd1);
    apply(0, 1, A_BLANK, 16'h0000);
    check("midrst_blank", 32'(data_out), 32'd0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
